// File: rtl/pixel_window_gen.sv
// Raster-order 2x4 window generator: a one-line buffer supplies the previous row
// and two 4-deep shift chains present the top/bottom neighbourhood to the scaler.
module pixel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic [7:0] T1,
  output logic [7:0] T2,
  output logic [7:0] T3,
  output logic [7:0] T4,
  output logic [7:0] B1,
  output logic [7:0] B2,
  output logic [7:0] B3,
  output logic [7:0] B4,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(3);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [3:0][7:0]  t_q, t_d;
  logic [3:0][7:0]  b_q, b_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       lb_q [IMG_WIDTH];
  logic [7:0]       lb_d [IMG_WIDTH];

  logic             acc;
  logic [COL_W-1:0] x;
  logic [ROW_W-1:0] y;
  logic [7:0]       lb_rd;

  always_comb begin
    acc   = in_valid && !rst;
    // in_sof overrides the running counters so a mid-frame restart lands on (0,0)
    x     = in_sof ? '0 : col_q;
    y     = in_sof ? '0 : row_q;
    lb_rd = lb_q[x[LB_AW-1:0]];

    col_d        = col_q;
    row_d        = row_q;
    t_d          = t_q;
    b_d          = b_q;
    lb_d         = lb_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (acc) begin
      t_d                = {lb_rd, t_q[3:1]};
      b_d                = {in_pix, b_q[3:1]};
      lb_d[x[LB_AW-1:0]] = in_pix;
      win_valid_d        = (x >= MIN_COL) && (y != '0);
      frame_done_d       = (x == LAST_COL) && (y == LAST_ROW);
      if (x < LAST_COL) begin
        col_d = x + COL_W'(1);
        row_d = y;
      end else if (y < LAST_ROW) begin
        col_d = '0;
        row_d = y + ROW_W'(1);
      end else begin
        col_d = '0;
        row_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      t_q          <= '0;
      b_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      t_q          <= t_d;
      b_q          <= b_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is deliberately not reset; row 0 never reads it into a window.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  assign T1         = t_q[0];
  assign T2         = t_q[1];
  assign T3         = t_q[2];
  assign T4         = t_q[3];
  assign B1         = b_q[0];
  assign B2         = b_q[1];
  assign B3         = b_q[2];
  assign B4         = b_q[3];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_window_gen.sv
// Randomized bench for pixel_window_gen on an 8x4 image, compared against an
// image-array reference model of the expected neighbourhoods.
module tb_pixel_window_gen;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_sof;
  logic [7:0] in_pix;
  logic [7:0] T1, T2, T3, T4, B1, B2, B3, B4;
  logic       win_valid, frame_done;

  pixel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(3), .ROW_W(2)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  img [H][W];
  int          mx, my;
  logic        exp_wv, exp_fd;
  logic [63:0] exp_win;
  int          win_cnt, fd_cnt;
  logic [63:0] first_win, last_win;
  logic        got_first, fd_on_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] dut_win();
    return {T1, T2, T3, T4, B1, B2, B3, B4};
  endfunction

  task automatic clear_stats();
    win_cnt = 0; fd_cnt = 0; got_first = 1'b0; fd_on_last = 1'b0;
    first_win = '0; last_win = '0;
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] p);
    int x, y;
    rst = r; in_valid = v; in_sof = s; in_pix = p;
    @(posedge clk);
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (r) begin
      mx = 0; my = 0;
    end else if (v) begin
      x = s ? 0 : mx;
      y = s ? 0 : my;
      img[y][x] = p;
      if (x >= 3 && y >= 1) begin
        exp_wv  = 1'b1;
        exp_win = {img[y-1][x-3], img[y-1][x-2], img[y-1][x-1], img[y-1][x],
                   img[y][x-3],   img[y][x-2],   img[y][x-1],   img[y][x]};
      end
      exp_fd = (x == W-1) && (y == H-1);
      if (x < W-1) begin mx = x + 1; my = y; end
      else if (y < H-1) begin mx = 0; my = y + 1; end
      else begin mx = 0; my = 0; end
    end
    @(negedge clk);
    chk("win_valid", 64'(win_valid), 64'(exp_wv));
    chk("frame_done", 64'(frame_done), 64'(exp_fd));
    if (r) chk("reset_window", dut_win(), 64'h0);
    if (exp_wv) chk("window", dut_win(), exp_win);
    if (win_valid) begin
      win_cnt++;
      if (!got_first) begin first_win = dut_win(); got_first = 1'b1; end
      last_win   = dut_win();
      fd_on_last = frame_done;
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic send_frame(input logic sof_first, input int gap_pct, input logic rnd, input int npix);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, sof_first && (i == 0),
           rnd ? 8'($urandom) : 8'(16 * (i / W) + (i % W)));
    end
  endtask

  initial begin
    mx = 0; my = 0; exp_win = '0;
    clear_stats();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h55);

    // Ramp frame, continuous
    clear_stats();
    send_frame(1'b1, 0, 1'b0, W * H);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s1_first_window", first_win, 64'h00010203_10111213);
    chk("s2_win_count", 64'(win_cnt), 64'd15);
    chk("s2_fd_count", 64'(fd_cnt), 64'd1);
    chk("s2_last_window", last_win, 64'h24252627_34353637);
    chk("s2_fd_on_last", 64'(fd_on_last), 64'd1);

    // Same ramp with idle gaps
    clear_stats();
    send_frame(1'b1, 40, 1'b0, W * H);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s3_first_window", first_win, 64'h00010203_10111213);
    chk("s3_win_count", 64'(win_cnt), 64'd15);
    chk("s3_fd_count", 64'(fd_cnt), 64'd1);
    chk("s3_last_window", last_win, 64'h24252627_34353637);

    // Abort at (5,2) with in_sof, then full ramp frame
    clear_stats();
    send_frame(1'b1, 0, 1'b0, 2 * W + 5);
    chk("s4_aborted_fd", 64'(fd_cnt), 64'd0);
    clear_stats();
    send_frame(1'b1, 0, 1'b0, W * H);
    chk("s4_new_first_window", first_win, 64'h00010203_10111213);
    chk("s4_win_count", 64'(win_cnt), 64'd15);
    chk("s4_fd_count", 64'(fd_cnt), 64'd1);

    // Reset at pixel (4,1), then a ramp frame with no in_sof
    send_frame(1'b1, 0, 1'b0, W + 4);
    step(1'b1, 1'b1, 1'b0, 8'd20);
    clear_stats();
    send_frame(1'b0, 0, 1'b0, W * H);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s5_first_window", first_win, 64'h00010203_10111213);
    chk("s5_win_count", 64'(win_cnt), 64'd15);
    chk("s5_fd_count", 64'(fd_cnt), 64'd1);

    // Two frames back to back, in_sof only on the first
    clear_stats();
    send_frame(1'b1, 0, 1'b0, W * H);
    send_frame(1'b0, 0, 1'b1, W * H);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s6_win_count", 64'(win_cnt), 64'd30);
    chk("s6_fd_count", 64'(fd_cnt), 64'd2);

    // Random pixels and gaps over several frames
    clear_stats();
    for (int f = 0; f < 4; f++) send_frame(1'b1, 30, 1'b1, W * H);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rand_win_count", 64'(win_cnt), 64'd60);
    chk("rand_fd_count", 64'(fd_cnt), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
